fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/riscv_fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/fetch_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction fetch controller: the FSM state
// encoding, the data width, the halt word and the PC increment.
package riscv_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] HALT_WORD = XLEN'(32'h0000_0000);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding fetched instruction words for the decoder.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   clear                synchronous flush of all entries
//   push, push_data      write an entry (accepted when not full, or when popping)
//   pop                  remove the head entry (ignored when empty)
//   head_c               head entry, zero when empty
//   full_c, empty_c      occupancy flags
//   count                current occupancy
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_c,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_eff;
    logic             pop_eff;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign head_c  = empty_c ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted when a pop frees the head slot the same cycle.
    assign pop_eff  = pop && !empty_c;
    assign push_eff = push && (!full_c || pop_eff);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_eff) - CW'(pop_eff);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues single-outstanding reads to instruction
// memory, buffers returned words in a prefetch FIFO for the decoder, stops on
// the halt word and supports start/flush redirects.
// Ports:
//   clk, reset_n               clock, async active-low reset
//   start, start_pc            begin fetching at start_pc (from IDLE/HALT)
//   flush                      redirect to start_pc, dropping buffered/in-flight words
//   imem_req, imem_addr        memory read request and address
//   imem_rvalid, imem_rdata    in-order memory response
//   instr, instr_valid         FIFO head to the decoder
//   dec_ready                  decoder accepts instr this cycle
//   halted                     halt word seen and FIFO drained
module fetch_ctrl
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [XLEN-1:0] start_pc,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            dec_ready,
    output logic            halted
);

    fetch_state_e          state_q, state_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic                  discard_q, discard_d;

    logic                  req_c;
    logic                  rsp_live_c;
    logic                  rsp_halt_c;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    // Only one request is ever outstanding, so in FETCH the buffer slot check is just "not full".
    // A pending discard blocks new requests until the stale response has come back.
    assign req_c = (state_q == FETCH) && !discard_q && !fifo_full;

    assign rsp_live_c = imem_rvalid && (state_q == WAIT) && !discard_q;
    assign rsp_halt_c = (imem_rdata == HALT_WORD);

    assign fifo_push = rsp_live_c && !flush && !rsp_halt_c;
    assign fifo_pop  = instr_valid && dec_ready;

    assign imem_req    = req_c;
    assign imem_addr   = pc_q;
    assign instr_valid = !fifo_empty;
    assign halted      = (state_q == HALT) && (fifo_count == '0);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (fifo_push),
        .push_data (imem_rdata),
        .pop       (fifo_pop),
        .head_c    (instr),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state, PC and discard-flag logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;

        if (discard_q && imem_rvalid) begin
            discard_d = 1'b0;
        end

        if (flush) begin
            state_d = FETCH;
            pc_d    = start_pc;
            // Remember a request still in flight; a response arriving this very cycle is already dropped.
            discard_d = req_c || (((state_q == WAIT) || discard_q) && !imem_rvalid);
        end else begin
            unique case (state_q)
                IDLE, HALT: begin
                    if (start) begin
                        state_d = FETCH;
                        pc_d    = start_pc;
                    end
                end
                FETCH: begin
                    if (req_c) begin
                        state_d = WAIT;
                        pc_d    = pc_q + PC_STEP;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_d = rsp_halt_c ? HALT : FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= PC_RESET;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

endmodule
